// File: rtl/pipe_rr_issue_arbiter_if.sv
// Bundles the requester, shared-pipe and response signals of pipe_rr_issue_arbiter.
// The master modport is the arbiter's view; slave is the requester/pipe side.
interface pipe_rr_issue_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int WIDTH   = 8
);
   logic [NUM_REQ-1:0]       cfg_mask;
   logic [NUM_REQ-1:0]       req_vld;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       req_rdy;
   logic                     unit_in_vld;
   logic [WIDTH-1:0]         unit_in_data;
   logic                     unit_out_vld;
   logic [WIDTH-1:0]         unit_out_data;
   logic [NUM_REQ-1:0]       rsp_vld;
   logic [WIDTH-1:0]         rsp_data;

   modport master (
      input  cfg_mask, req_vld, req_data, unit_out_vld, unit_out_data,
      output req_rdy, unit_in_vld, unit_in_data, rsp_vld, rsp_data
   );

   modport slave (
      output cfg_mask, req_vld, req_data, unit_out_vld, unit_out_data,
      input  req_rdy, unit_in_vld, unit_in_data, rsp_vld, rsp_data
   );
endinterface

// File: rtl/pipe_rr_issue_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency pipe between NUM_REQ requesters.
// Optional tag/valid mismatch detection (err_tag, err_cnt) under PIPE_RR_ARB_TAG_CHECK_EN.
module pipe_rr_issue_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int WIDTH   = 8,
   parameter int LATENCY = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   pipe_rr_issue_arbiter_if.master bus
`ifdef PIPE_RR_ARB_TAG_CHECK_EN
   ,
   output logic                   err_tag,
   output logic [7:0]             err_cnt
`endif
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDW-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0] elig;
   logic               gnt_vld;
   logic [IDW-1:0]     gnt_idx;
   int                 cand;

   // First eligible requester at or above ptr_q, wrapping past NUM_REQ-1.
   always_comb begin
      elig    = bus.req_vld & bus.cfg_mask;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!gnt_vld && elig[cand[IDW-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand[IDW-1:0];
         end
      end
   end

   assign bus.req_rdy      = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
   assign bus.unit_in_vld  = gnt_vld;
   assign bus.unit_in_data = gnt_vld ? bus.req_data[int'(gnt_idx)*WIDTH +: WIDTH] : '0;

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_vld) ptr_d = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + IDW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   logic [LATENCY-1:0] tvld_q;
   logic [IDW-1:0]     tid_q [LATENCY];
   logic               tvld_head;
   logic [IDW-1:0]     tid_head;

   assign tvld_head = tvld_q[LATENCY-1];
   assign tid_head  = tid_q[LATENCY-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         tvld_q <= '0;
      end else begin
         tvld_q[0] <= gnt_vld;
         for (int i = 1; i < LATENCY; i++) tvld_q[i] <= tvld_q[i-1];
      end
   end

   // Owner ids are qualified by tvld, so they need no reset.
   always_ff @(posedge clk) begin
      tid_q[0] <= gnt_idx;
      for (int i = 1; i < LATENCY; i++) tid_q[i] <= tid_q[i-1];
   end

   logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
   logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;

   always_comb begin
      rsp_vld_d  = '0;
      rsp_data_d = rsp_data_q;
      if (bus.unit_out_vld && tvld_head) rsp_vld_d = NUM_REQ'(1) << tid_head;
      if (bus.unit_out_vld) rsp_data_d = bus.unit_out_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_vld_q  <= '0;
         rsp_data_q <= '0;
      end else begin
         rsp_vld_q  <= rsp_vld_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   assign bus.rsp_vld  = rsp_vld_q;
   assign bus.rsp_data = rsp_data_q;

`ifdef PIPE_RR_ARB_TAG_CHECK_EN
   logic       tag_mis;
   logic       err_tag_q, err_tag_d;
   logic [7:0] err_cnt_q, err_cnt_d;

   assign tag_mis = bus.unit_out_vld ^ tvld_head;

   always_comb begin
      err_tag_d = err_tag_q | tag_mis;
      err_cnt_d = err_cnt_q;
      if (tag_mis && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_tag_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         err_tag_q <= err_tag_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_tag = err_tag_q;
   assign err_cnt = err_cnt_q;
`endif
endmodule
